// File: rtl/fetch_ctrl_unit.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_unit
//
// Instruction-fetch front end feeding the IF/ID register. Owns the PC, issues
// one outstanding request at a time to a variable-latency instruction memory,
// and loads the IF/ID fields (instruction, fetched PC + 4, valid).
// Branch redirects flush IF/ID and retarget the PC. Stalls from the hazard
// unit hold IF/ID.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_branch           redirect target address
//   in_branchSel        redirect strobe; wins over everything except reset
//   in_stall            decode cannot accept this cycle
//   imem_req/imem_addr  one-cycle request pulse and its address (= pc)
//   imem_valid/rdata    memory response strobe and instruction word
//   out_instruction     IF/ID instruction
//   out_incremented_pc  IF/ID fetched PC + 4
//   out_valid           IF/ID holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_ctrl_unit #(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in_branch,
   input  logic        in_branchSel,
   input  logic        in_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] out_instruction,
   output logic [31:0] out_incremented_pc,
   output logic        out_valid
);

   // REQ   : request goes out this cycle
   // WAIT  : request outstanding, awaiting the response
   // FULL  : response parked in the skid buffer, waiting for IF/ID to free up
   // DRAIN : a request made obsolete by a redirect is still outstanding
   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FULL  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] inc_pc_q, inc_pc_d;
   logic        valid_q, valid_d;
   // Skid buffer payload. Occupancy is implied by state FULL, so leaving FULL
   // (redirect, reset or drain into IF/ID) empties it.
   logic [31:0] skid_data_q, skid_data_d;

   logic        loadable;
   logic [31:0] pc_plus4;

   // A bubble may always be overwritten, even while decode is stalled.
   assign loadable = ~in_stall | ~valid_q;
   // Wraps modulo 2^32 by construction.
   assign pc_plus4 = pc_q + 32'd4;

   assign imem_req           = (state_q == ST_REQ) & ~reset & ~in_branchSel;
   assign imem_addr          = pc_q;
   assign out_instruction    = instr_q;
   assign out_incremented_pc = inc_pc_q;
   assign out_valid          = valid_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      inc_pc_d    = inc_pc_q;
      valid_d     = valid_q;
      skid_data_d = skid_data_q;

      // Decode takes the current entry; a load below overrides this.
      if (valid_q && !in_stall) begin
         valid_d = 1'b0;
      end

      if (in_branchSel) begin
         pc_d    = in_branch;
         valid_d = 1'b0;
         // Only a request still in flight needs draining. A response landing in
         // the redirect cycle retires that request, so go straight to REQ.
         if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !imem_valid) begin
            state_d = ST_DRAIN;
         end else begin
            state_d = ST_REQ;
         end
      end else begin
         case (state_q)
            ST_REQ: begin
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_valid) begin
                  pc_d = pc_plus4;
                  if (loadable) begin
                     instr_d  = imem_rdata;
                     inc_pc_d = pc_plus4;
                     valid_d  = 1'b1;
                     state_d  = ST_REQ;
                  end else begin
                     skid_data_d = imem_rdata;
                     state_d     = ST_FULL;
                  end
               end
            end
            ST_FULL: begin
               if (loadable) begin
                  instr_d  = skid_data_q;
                  // pc already advanced past the buffered word when it was parked.
                  inc_pc_d = pc_q;
                  valid_d  = 1'b1;
                  state_d  = ST_REQ;
               end
            end
            ST_DRAIN: begin
               if (imem_valid) begin
                  state_d = ST_REQ;
               end
            end
            default: begin
               state_d = ST_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_REQ;
         pc_q        <= RESET_PC;
         instr_q     <= 32'd0;
         inc_pc_q    <= 32'd0;
         valid_q     <= 1'b0;
         skid_data_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         inc_pc_q    <= inc_pc_d;
         valid_q     <= valid_d;
         skid_data_q <= skid_data_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
module tb_fetch_ctrl_unit;

   logic        clk;
   logic        reset;
   logic [31:0] in_branch;
   logic        in_branchSel;
   logic        in_stall;
   logic        imem_req, imem_valid;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] out_instruction, out_incremented_pc;
   logic        out_valid;
   logic        imem_req2, imem_valid2;
   logic [31:0] imem_addr2, imem_rdata2;
   logic [31:0] out_instruction2, out_incremented_pc2;
   logic        out_valid2;

   int checks = 0;
   int errors = 0;

   // memory model / request monitor state
   int          mem_lat = 1;
   logic        mem_flush = 1'b1;
   int          cyc = 0;
   logic        m1_pend = 1'b0, m2_pend = 1'b0;
   int          m1_cnt = 0;
   logic [31:0] m1_addr = 32'd0, m2_addr = 32'd0;
   logic [63:0] obs_arr [0:255];
   int          obs_wr = 0;
   int          obs_rd = 0;
   logic [63:0] exp_q [$];

   fetch_ctrl_unit dut (
      .clk(clk), .reset(reset), .in_branch(in_branch), .in_branchSel(in_branchSel),
      .in_stall(in_stall), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .out_instruction(out_instruction), .out_incremented_pc(out_incremented_pc),
      .out_valid(out_valid)
   );

   fetch_ctrl_unit #(.RESET_PC(32'hFFFFFFFC)) dut2 (
      .clk(clk), .reset(reset), .in_branch(in_branch), .in_branchSel(in_branchSel),
      .in_stall(in_stall), .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_valid(imem_valid2), .imem_rdata(imem_rdata2),
      .out_instruction(out_instruction2), .out_incremented_pc(out_incremented_pc2),
      .out_valid(out_valid2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd0) return 32'h11111111;
      if (a == 32'd4) return 32'h22222222;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory for dut: latency mem_lat, records every request with its cycle.
   // cyc counts cycles after reset release (first post-reset cycle = 1).
   always @(posedge clk) begin : mem1
      logic        v;
      logic [31:0] d;
      if (imem_req === 1'b1) begin
         obs_arr[obs_wr[7:0]] = {cyc[31:0], imem_addr};
         obs_wr = obs_wr + 1;
      end
      cyc = (reset === 1'b1) ? 1 : cyc + 1;
      if (mem_flush) m1_pend = 1'b0;
      if (imem_req === 1'b1) begin
         m1_pend = 1'b1;
         m1_cnt  = mem_lat;
         m1_addr = imem_addr;
      end
      v = 1'b0;
      d = 32'd0;
      if (m1_pend) begin
         if (m1_cnt <= 1) begin
            v = 1'b1;
            d = mem_word(m1_addr);
            m1_pend = 1'b0;
         end else begin
            m1_cnt = m1_cnt - 1;
         end
      end
      #1;
      imem_valid = v;
      imem_rdata = d;
   end

   // Memory for dut2: fixed 1-cycle latency.
   always @(posedge clk) begin : mem2
      logic        v;
      logic [31:0] d;
      if (mem_flush) m2_pend = 1'b0;
      if (imem_req2 === 1'b1) begin
         m2_pend = 1'b1;
         m2_addr = imem_addr2;
      end
      v = 1'b0;
      d = 32'd0;
      if (m2_pend) begin
         v = 1'b1;
         d = mem_word(m2_addr);
         m2_pend = 1'b0;
      end
      #1;
      imem_valid2 = v;
      imem_rdata2 = d;
   end

   // Leaves the bench mid-cycle 1 (first cycle after reset release).
   task automatic do_reset();
      reset = 1'b1; mem_flush = 1'b1;
      in_branchSel = 1'b0; in_stall = 1'b0; in_branch = 32'd0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0; mem_flush = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      logic [63:0] a, e;
      reset = 1'b1; mem_flush = 1'b1; mem_lat = 1;
      in_branchSel = 1'b0; in_stall = 1'b0; in_branch = 32'd0;
      @(negedge clk); @(negedge clk);
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== 65'd0) begin
         errors++; $display("FAIL reset_outs: got %b/%h/%h want 0/0/0", out_valid, out_instruction, out_incremented_pc); end
      checks++; if ({imem_req, imem_addr} !== {1'b0, 32'd0}) begin
         errors++; $display("FAIL reset_req: got req=%b addr=%h want 0/0", imem_req, imem_addr); end
      reset = 1'b0; mem_flush = 1'b0; #1;
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
         errors++; $display("FAIL reset_first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
      exp_q.push_back({32'd1, 32'd0});
      @(negedge clk);
      while (obs_rd < obs_wr) begin
         a = obs_arr[obs_rd[7:0]]; obs_rd++; checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL reset_reqseq: got cyc %0d addr %h want none", a[63:32], a[31:0]); end
         else begin e = exp_q.pop_front(); if (a !== e) begin errors++;
            $display("FAIL reset_reqseq: got cyc %0d addr %h want cyc %0d addr %h", a[63:32], a[31:0], e[63:32], e[31:0]); end end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_reqmiss: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_basic();
      logic [63:0] a, e;
      mem_lat = 1; do_reset();                                   // cycle 1
      exp_q.push_back({32'd1, 32'd0});
      @(negedge clk);                                            // cycle 2
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat: got valid %b want 0", out_valid); end
      @(negedge clk);                                            // cycle 3
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== {1'b1, 32'h11111111, 32'd4}) begin
         errors++; $display("FAIL basic_w0: got %b/%h/%h want 1/11111111/4", out_valid, out_instruction, out_incremented_pc); end
      exp_q.push_back({32'd3, 32'd4});
      @(negedge clk);                                            // cycle 4
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_wait_req: got %b want 0", imem_req); end
      @(negedge clk);                                            // cycle 5
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== {1'b1, 32'h22222222, 32'd8}) begin
         errors++; $display("FAIL basic_w1: got %b/%h/%h want 1/22222222/8", out_valid, out_instruction, out_incremented_pc); end
      exp_q.push_back({32'd5, 32'd8});
      @(negedge clk);                                            // cycle 6: consumed, fields hold
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== {1'b0, 32'h22222222, 32'd8}) begin
         errors++; $display("FAIL basic_consume: got %b/%h/%h want 0/22222222/8", out_valid, out_instruction, out_incremented_pc); end
      while (obs_rd < obs_wr) begin
         a = obs_arr[obs_rd[7:0]]; obs_rd++; checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL basic_reqseq: got cyc %0d addr %h want none", a[63:32], a[31:0]); end
         else begin e = exp_q.pop_front(); if (a !== e) begin errors++;
            $display("FAIL basic_reqseq: got cyc %0d addr %h want cyc %0d addr %h", a[63:32], a[31:0], e[63:32], e[31:0]); end end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_reqmiss: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_stall();
      logic [63:0] a, e;
      mem_lat = 1; do_reset(); in_stall = 1'b1;                  // cycle 1
      exp_q.push_back({32'd1, 32'd0});
      @(negedge clk); @(negedge clk);                            // cycle 3: bubble filled under stall
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== {1'b1, 32'h11111111, 32'd4}) begin
         errors++; $display("FAIL stall_fill: got %b/%h/%h want 1/11111111/4", out_valid, out_instruction, out_incremented_pc); end
      exp_q.push_back({32'd3, 32'd4});
      for (int c = 5; c <= 6; c++) begin
         if (c == 5) begin @(negedge clk); end
         @(negedge clk);                                         // cycles 5, 6: FULL
         checks++; if ({imem_req, out_valid, out_instruction, out_incremented_pc} !== {2'b01, 32'h11111111, 32'd4}) begin
            errors++; $display("FAIL stall_hold_c%0d: got req %b %b/%h/%h want 0 1/11111111/4", c, imem_req, out_valid, out_instruction, out_incremented_pc); end
      end
      in_stall = 1'b0;
      @(negedge clk);                                            // cycle 7
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== {1'b1, 32'h22222222, 32'd8}) begin
         errors++; $display("FAIL stall_skid: got %b/%h/%h want 1/22222222/8", out_valid, out_instruction, out_incremented_pc); end
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'd8}) begin
         errors++; $display("FAIL stall_req8: got req=%b addr=%h want 1/8", imem_req, imem_addr); end
      exp_q.push_back({32'd7, 32'd8});
      @(negedge clk);                                            // cycle 8
      while (obs_rd < obs_wr) begin
         a = obs_arr[obs_rd[7:0]]; obs_rd++; checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL stall_reqseq: got cyc %0d addr %h want none", a[63:32], a[31:0]); end
         else begin e = exp_q.pop_front(); if (a !== e) begin errors++;
            $display("FAIL stall_reqseq: got cyc %0d addr %h want cyc %0d addr %h", a[63:32], a[31:0], e[63:32], e[31:0]); end end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_reqmiss: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_redirect_wait();
      logic [63:0] a, e;
      mem_lat = 3; do_reset(); in_stall = 1'b1;                  // cycle 1
      exp_q.push_back({32'd1, 32'd0});
      repeat (4) @(negedge clk);                                 // cycle 5
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== {1'b1, 32'h11111111, 32'd4}) begin
         errors++; $display("FAIL rdw_w0: got %b/%h/%h want 1/11111111/4", out_valid, out_instruction, out_incremented_pc); end
      exp_q.push_back({32'd5, 32'd4});
      @(negedge clk);                                            // cycle 6: WAIT, redirect
      in_branchSel = 1'b1; in_branch = 32'h40;
      @(negedge clk);                                            // cycle 7
      in_branchSel = 1'b0; in_stall = 1'b0; #1;
      checks++; if ({imem_req, out_valid} !== 2'b00) begin
         errors++; $display("FAIL rdw_flush: got req %b valid %b want 0 0", imem_req, out_valid); end
      @(negedge clk); @(negedge clk);                            // cycle 9: old word dropped
      checks++; if ({out_valid, imem_req, imem_addr} !== {2'b01, 32'h40}) begin
         errors++; $display("FAIL rdw_req40: got valid %b req %b addr %h want 0 1 40", out_valid, imem_req, imem_addr); end
      exp_q.push_back({32'd9, 32'h40});
      repeat (4) @(negedge clk);                                 // cycle 13
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== {1'b1, mem_word(32'h40), 32'h44}) begin
         errors++; $display("FAIL rdw_target: got %b/%h/%h want 1/%h/44", out_valid, out_instruction, out_incremented_pc, mem_word(32'h40)); end
      while (obs_rd < obs_wr) begin
         a = obs_arr[obs_rd[7:0]]; obs_rd++; checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL rdw_reqseq: got cyc %0d addr %h want none", a[63:32], a[31:0]); end
         else begin e = exp_q.pop_front(); if (a !== e) begin errors++;
            $display("FAIL rdw_reqseq: got cyc %0d addr %h want cyc %0d addr %h", a[63:32], a[31:0], e[63:32], e[31:0]); end end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rdw_reqmiss: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_redirect_resp();
      logic [63:0] a, e;
      mem_lat = 1; do_reset(); in_stall = 1'b1;                  // cycle 1
      exp_q.push_back({32'd1, 32'd0});
      @(negedge clk); @(negedge clk);                            // cycle 3
      exp_q.push_back({32'd3, 32'd4});
      @(negedge clk);                                            // cycle 4: response + redirect
      in_branchSel = 1'b1; in_branch = 32'h80;
      @(negedge clk);                                            // cycle 5
      in_branchSel = 1'b0; #1;
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== {1'b0, 32'h11111111, 32'd4}) begin
         errors++; $display("FAIL rdr_flush: got %b/%h/%h want 0/11111111/4", out_valid, out_instruction, out_incremented_pc); end
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h80}) begin
         errors++; $display("FAIL rdr_req80: got req=%b addr=%h want 1/80", imem_req, imem_addr); end
      in_branchSel = 1'b1; in_stall = 1'b0; #1;                  // redirect while in REQ
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdr_req_suppress: got %b want 0", imem_req); end
      @(negedge clk);                                            // cycle 6
      in_branchSel = 1'b0; #1;
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h80}) begin
         errors++; $display("FAIL rdr_req80b: got req=%b addr=%h want 1/80", imem_req, imem_addr); end
      exp_q.push_back({32'd6, 32'h80});
      @(negedge clk); @(negedge clk);                            // cycle 8
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== {1'b1, mem_word(32'h80), 32'h84}) begin
         errors++; $display("FAIL rdr_target: got %b/%h/%h want 1/%h/84", out_valid, out_instruction, out_incremented_pc, mem_word(32'h80)); end
      while (obs_rd < obs_wr) begin
         a = obs_arr[obs_rd[7:0]]; obs_rd++; checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL rdr_reqseq: got cyc %0d addr %h want none", a[63:32], a[31:0]); end
         else begin e = exp_q.pop_front(); if (a !== e) begin errors++;
            $display("FAIL rdr_reqseq: got cyc %0d addr %h want cyc %0d addr %h", a[63:32], a[31:0], e[63:32], e[31:0]); end end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rdr_reqmiss: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_reset_full();
      logic [63:0] a, e;
      mem_lat = 1; do_reset(); in_stall = 1'b1;                  // cycle 1
      exp_q.push_back({32'd1, 32'd0});
      @(negedge clk); @(negedge clk);                            // cycle 3
      exp_q.push_back({32'd3, 32'd4});
      @(negedge clk); @(negedge clk);                            // cycle 5: FULL
      reset = 1'b1;
      @(negedge clk);                                            // reset still held
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== 65'd0) begin
         errors++; $display("FAIL rf_outs: got %b/%h/%h want 0/0/0", out_valid, out_instruction, out_incremented_pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rf_req_in_reset: got %b want 0", imem_req); end
      @(negedge clk);
      reset = 1'b0; in_stall = 1'b0; #1;                         // first post-reset cycle
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
         errors++; $display("FAIL rf_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
      exp_q.push_back({32'd1, 32'd0});
      @(negedge clk); @(negedge clk);
      checks++; if ({out_valid, out_instruction, out_incremented_pc} !== {1'b1, 32'h11111111, 32'd4}) begin
         errors++; $display("FAIL rf_w0: got %b/%h/%h want 1/11111111/4", out_valid, out_instruction, out_incremented_pc); end
      while (obs_rd < obs_wr) begin
         a = obs_arr[obs_rd[7:0]]; obs_rd++; checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL rf_reqseq: got cyc %0d addr %h want none", a[63:32], a[31:0]); end
         else begin e = exp_q.pop_front(); if (a !== e) begin errors++;
            $display("FAIL rf_reqseq: got cyc %0d addr %h want cyc %0d addr %h", a[63:32], a[31:0], e[63:32], e[31:0]); end end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rf_reqmiss: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_wrap();
      logic [63:0] a, e;
      mem_lat = 1; do_reset();                                   // cycle 1
      exp_q.push_back({32'd1, 32'd0});
      checks++; if ({imem_req2, imem_addr2} !== {1'b1, 32'hFFFFFFFC}) begin
         errors++; $display("FAIL wrap_req0: got req=%b addr=%h want 1/fffffffc", imem_req2, imem_addr2); end
      @(negedge clk); @(negedge clk);                            // cycle 3
      checks++; if ({out_valid2, out_instruction2, out_incremented_pc2} !== {1'b1, mem_word(32'hFFFFFFFC), 32'd0}) begin
         errors++; $display("FAIL wrap_out: got %b/%h/%h want 1/%h/0", out_valid2, out_instruction2, out_incremented_pc2, mem_word(32'hFFFFFFFC)); end
      checks++; if ({imem_req2, imem_addr2} !== {1'b1, 32'd0}) begin
         errors++; $display("FAIL wrap_req1: got req=%b addr=%h want 1/0", imem_req2, imem_addr2); end
      exp_q.push_back({32'd3, 32'd4});
      @(negedge clk);
      while (obs_rd < obs_wr) begin
         a = obs_arr[obs_rd[7:0]]; obs_rd++; checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_reqseq: got cyc %0d addr %h want none", a[63:32], a[31:0]); end
         else begin e = exp_q.pop_front(); if (a !== e) begin errors++;
            $display("FAIL wrap_reqseq: got cyc %0d addr %h want cyc %0d addr %h", a[63:32], a[31:0], e[63:32], e[31:0]); end end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_reqmiss: got %0d missing want 0", exp_q.size()); exp_q.delete(); end
   endtask

   initial begin
      reset = 1'b1; in_branch = 32'd0; in_branchSel = 1'b0; in_stall = 1'b0;
      imem_valid = 1'b0; imem_rdata = 32'd0; imem_valid2 = 1'b0; imem_rdata2 = 32'd0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_stall();
      test_redirect_wait();
      test_redirect_resp();
      test_reset_full();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
